// File: rtl/fa_bist_pkg.sv
// Shared definitions for the full-adder BIST controller: state encoding,
// vector count, field widths and the golden full-adder response.
package fa_bist_pkg;

    localparam int unsigned NUM_VECTORS = 8;
    localparam int unsigned VEC_W       = 3;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned ERR_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Golden response for vector {A,B,Cin}, returned as {Cout,S}.
    function automatic logic [1:0] fa_expected(input logic [VEC_W-1:0] v);
        logic a;
        logic b;
        logic c;
        a = v[2];
        b = v[1];
        c = v[0];
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/fa_bist_controller.sv
// Exhaustive self-test sequencer for a single full adder: walks the eight
// input vectors, compares the response and reports a per-vector fail map.
module fa_bist_controller
    import fa_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned STOP_ON_FAIL  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             A,
    output logic             B,
    output logic             Cin,
    input  logic             S,
    input  logic             Cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       fail_vec
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(NUM_VECTORS - 1);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] v_q, v_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [VEC_W-1:0] abc_q, abc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [7:0]       fail_q, fail_d;
    logic             mismatch_c;

    assign mismatch_c = ({Cout, S} != fa_expected(v_q));

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        abc_d   = '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_APPLY;
                    v_d     = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            ST_APPLY: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (mismatch_c) begin
                    err_d       = err_q + ERR_W'(1);
                    fail_d[v_q] = 1'b1;
                end
                if ((v_q == VEC_LAST) || (mismatch_c && (STOP_ON_FAIL != 0))) begin
                    state_d = ST_DONE;
                end else begin
                    v_d     = v_q + VEC_W'(1);
                    state_d = ST_APPLY;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_APPLY) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
        abc_d  = busy_d ? v_d : '0;
        // Verdict is latched once, on the transition into DONE.
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            pass_d = (err_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            v_q     <= '0;
            cnt_q   <= '0;
            abc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            abc_q   <= abc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign {A, B, Cin} = abc_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_count   = err_q;
    assign fail_vec    = fail_q;

endmodule

// File: tb/tb_fa_bist_controller.sv
// Bench: two controller instances (free-running and stop-on-fail) beside a
// fault-injectable full adder, checked every cycle against a run-schedule model.
module tb_fa_bist_controller;

    logic clk;
    logic rst_n;
    logic start;
    logic [7:0] s_flip;
    logic [7:0] c_flip;

    logic [1:0] a_w, b_w, cin_w, s_w, cout_w, busy_w, done_w, pass_w;
    logic [3:0] err_w [2];
    logic [7:0] fail_w [2];

    int checks = 0;
    int errors = 0;

    int sc_of  [2] = '{1, 3};
    bit sof_of [2] = '{1'b0, 1'b1};

    fa_bist_controller #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .A(a_w[0]), .B(b_w[0]), .Cin(cin_w[0]), .S(s_w[0]), .Cout(cout_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(err_w[0]), .fail_vec(fail_w[0])
    );

    fa_bist_controller #(.SETTLE_CYCLES(3), .STOP_ON_FAIL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .A(a_w[1]), .B(b_w[1]), .Cin(cin_w[1]), .S(s_w[1]), .Cout(cout_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(err_w[1]), .fail_vec(fail_w[1])
    );

    // Adder under test; a set bit in s_flip/c_flip corrupts that vector's output.
    for (genvar g = 0; g < 2; g++) begin : g_fa
        assign s_w[g]    = a_w[g] ^ b_w[g] ^ cin_w[g] ^ s_flip[{a_w[g], b_w[g], cin_w[g]}];
        assign cout_w[g] = ((a_w[g] & b_w[g]) | (a_w[g] & cin_w[g]) | (b_w[g] & cin_w[g]))
                           ^ c_flip[{a_w[g], b_w[g], cin_w[g]}];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Run-schedule model: k counts edges since the accepting edge.
    bit       m_run   [2];
    bit       m_done  [2];
    bit       m_pass  [2];
    int       m_k     [2];
    int       m_endk  [2];
    int       m_last  [2];
    bit [7:0] m_bad   [2];
    bit [7:0] m_ffail [2];

    function automatic bit [7:0] seen_fail(input int i, input int k);
        bit [7:0] mask = '0;
        for (int v = 0; v < 8; v++)
            if (v <= m_last[i] && m_bad[i][v] && (v + 1) * (sc_of[i] + 1) <= k)
                mask[v] = 1'b1;
        return mask;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    m_run[i] = 0; m_done[i] = 0; m_pass[i] = 0;
                    m_k[i] = 0; m_ffail[i] = '0; m_bad[i] = '0; m_last[i] = 7;
                end else if (m_run[i]) begin
                    m_k[i]++;
                    if (m_k[i] == m_endk[i]) begin
                        m_run[i]   = 0;
                        m_done[i]  = 1;
                        m_ffail[i] = seen_fail(i, m_endk[i]);
                        m_pass[i]  = (m_ffail[i] == 0);
                    end
                end else if (start) begin
                    m_run[i]   = 1;
                    m_k[i]     = 0;
                    m_done[i]  = 0;
                    m_pass[i]  = 0;
                    m_ffail[i] = '0;
                    m_bad[i]   = s_flip | c_flip;
                    m_last[i]  = 7;
                    if (sof_of[i])
                        for (int v = 7; v >= 0; v--)
                            if (m_bad[i][v]) m_last[i] = v;
                    m_endk[i] = (m_last[i] + 1) * (sc_of[i] + 1);
                end
            end
        end
    end

    function automatic logic [17:0] model_out(input int i);
        bit [7:0] f;
        bit [2:0] abc;
        if (m_run[i]) begin
            f   = seen_fail(i, m_k[i]);
            abc = 3'(m_k[i] / (sc_of[i] + 1));
            return {1'b1, 1'b0, 1'b0, abc, 4'($countones(f)), f};
        end
        f = m_ffail[i];
        return {1'b0, m_done[i], m_pass[i], 3'b000, 4'($countones(f)), f};
    endfunction

    function automatic logic [17:0] obs(input int i);
        return {busy_w[i], done_w[i], pass_w[i], a_w[i], b_w[i], cin_w[i], err_w[i], fail_w[i]};
    endfunction

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== model_out(i)) begin
                errors++;
                $display("FAIL cycle_model inst%0d t=%0t got %h expected %h",
                         i, $time, obs(i), model_out(i));
            end
        end
    end

    task automatic check_eq(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, expv);
        end
    endtask

    // Pulse start, then report the cycle count to done for both instances.
    task automatic time_run(input bit repulse, output int t0, output int t1);
        t0 = 0;
        t1 = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 200 && (t0 == 0 || t1 == 0); n++) begin
            @(posedge clk);
            #1;
            if (done_w[0] && t0 == 0) t0 = n;
            if (done_w[1] && t1 == 0) t1 = n;
            start = repulse && (n == 3 || n == 9);
        end
        start = 1'b0;
    endtask

    int  t0, t1;
    bit  found;
    bit  idle_ok;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        s_flip = '0;
        c_flip = '0;
        #1;
        check_eq("reset_inst0", int'(obs(0)), 0);
        check_eq("reset_inst1", int'(obs(1)), 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Fault-free adder
        time_run(1'b0, t0, t1);
        check_eq("clean_latency0", t0, 16);
        check_eq("clean_latency1", t1, 32);
        check_eq("clean_pass0", int'(pass_w[0]), 1);
        check_eq("clean_err0", int'(err_w[0]), 0);
        check_eq("clean_fail0", int'(fail_w[0]), 8'h00);

        // S stuck at 0
        s_flip = 8'h96;
        time_run(1'b0, t0, t1);
        check_eq("s0_latency0", t0, 16);
        check_eq("s0_err0", int'(err_w[0]), 4);
        check_eq("s0_fail0", int'(fail_w[0]), 8'h96);
        check_eq("s0_pass0", int'(pass_w[0]), 0);
        check_eq("s0_stop_latency1", t1, 8);
        check_eq("s0_stop_err1", int'(err_w[1]), 1);
        check_eq("s0_stop_fail1", int'(fail_w[1]), 8'h02);

        // Cout inverted
        s_flip = 8'h00;
        c_flip = 8'hFF;
        time_run(1'b0, t0, t1);
        check_eq("cinv_err0", int'(err_w[0]), 8);
        check_eq("cinv_fail0", int'(fail_w[0]), 8'hFF);
        check_eq("cinv_pass0", int'(pass_w[0]), 0);
        check_eq("cinv_stop_latency1", t1, 4);
        check_eq("cinv_stop_fail1", int'(fail_w[1]), 8'h01);

        // start re-pulsed while busy
        c_flip = 8'h00;
        time_run(1'b1, t0, t1);
        check_eq("repulse_latency0", t0, 16);
        check_eq("repulse_latency1", t1, 32);
        check_eq("repulse_pass0", int'(pass_w[0]), 1);

        // Reset mid-run at vector 3
        s_flip = 8'h96;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        found = 0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(posedge clk);
            #1;
            if ({a_w[0], b_w[0], cin_w[0]} == 3'd3) found = 1;
        end
        check_eq("reach_vector3", int'(found), 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("abort_inst0", int'(obs(0)), 0);
        check_eq("abort_inst1", int'(obs(1)), 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_after_abort", int'({busy_w[0], done_w[0], busy_w[1], done_w[1]}), 0);
        s_flip = 8'h00;
        time_run(1'b0, t0, t1);
        check_eq("rerun_latency0", t0, 16);
        check_eq("rerun_pass0", int'(pass_w[0]), 1);
        check_eq("rerun_fail0", int'(fail_w[0]), 8'h00);

        // Randomized faults, start patterns and occasional async resets
        for (int it = 0; it < 40; it++) begin
            s_flip = ($urandom % 3 == 0) ? 8'h00 : 8'($urandom);
            c_flip = ($urandom % 3 == 0) ? 8'h00 : 8'($urandom);
            for (int c = 0; c < 80; c++) begin
                @(posedge clk);
                #2;
                start = (it % 5 == 0) ? 1'b1 : ($urandom % 4 == 0);
                if ($urandom % 200 == 0) begin
                    rst_n = 1'b0;
                    #1 rst_n = 1'b1;
                end
            end
            start   = 1'b0;
            idle_ok = 0;
            for (int n = 0; n < 200 && !idle_ok; n++) begin
                @(posedge clk);
                #2;
                idle_ok = !m_run[0] && !m_run[1];
            end
            check_eq("drain_idle", int'(idle_ok), 1);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
